// File: rtl/func_pkg.sv
// Shared widths, sentinel and controller state type for the func core
// initiator and its result FIFO.
package func_pkg;

   localparam int FUNC_A_W = 8;
   localparam int FUNC_B_W = 8;
   localparam int FUNC_Y_W = 25;

   localparam logic [FUNC_Y_W-1:0] FUNC_Y_SENTINEL = 25'h1FFFFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } func_state_e;

endpackage

// File: rtl/func_ctrl_rfifo.sv
// Two-entry in-order result FIFO with head read-out (0 when empty)
// and asynchronous active-high reset.
module func_ctrl_rfifo
   import func_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic [FUNC_Y_W-1:0] push_data,
   input  logic                pop,
   output logic [1:0]          count,
   output logic [FUNC_Y_W-1:0] head
);

   logic [FUNC_Y_W-1:0] mem [2];
   logic                rd_ptr;
   logic                wr_ptr;
   logic                do_push;
   logic                do_pop;

   assign do_pop  = pop & (count != 2'd0);
   assign do_push = push & ((count != 2'd2) | do_pop);
   assign head    = (count != 2'd0) ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         // push+pop together leaves the count alone
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/func_ctrl.sv
// Start/busy initiator for the func core with a 2-entry result FIFO.
// Define FUNC_CTRL_TIMEOUT_EN to enable the WAIT watchdog and err_o.
module func_ctrl
   import func_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [FUNC_A_W-1:0] a_bi,
   input  logic [FUNC_B_W-1:0] b_bi,
   output logic                func_start_o,
   output logic [FUNC_A_W-1:0] func_a_bo,
   output logic [FUNC_B_W-1:0] func_b_bo,
   input  logic                func_busy_i,
   input  logic [FUNC_Y_W-1:0] func_y_bi,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [FUNC_Y_W-1:0] y_bo,
   output logic                err_o
);

   func_state_e         state;
   logic [1:0]          count;
   logic                hs;
   logic                push;
   logic                pop;
   logic [FUNC_Y_W-1:0] push_y;

   assign in_ready_o   = (state == ST_IDLE) & (count < 2'd2);
   assign hs           = in_valid_i & in_ready_o;
   assign func_start_o = (state == ST_START);
   assign out_valid_o  = (count != 2'd0);
   assign pop          = out_valid_o & out_ready_i;

`ifdef FUNC_CTRL_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TO_W-1:0] to_cnt;
   logic            to_hit;
   logic            err_q;

   assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
   assign err_o  = err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         to_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state == ST_START) begin
            to_cnt <= '0;
         end else if (state == ST_WAIT) begin
            to_cnt <= to_cnt + TO_W'(1);
         end
         if ((state == ST_WAIT) && func_busy_i && to_hit) begin
            err_q <= 1'b1;
         end
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign err_o          = 1'b0;
`endif

   always_comb begin
      push   = 1'b0;
      push_y = func_y_bi;
      if (state == ST_WAIT) begin
         if (!func_busy_i) begin
            push = 1'b1;
`ifdef FUNC_CTRL_TIMEOUT_EN
         end else if (to_hit) begin
            push   = 1'b1;
            push_y = FUNC_Y_SENTINEL;
`endif
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= ST_IDLE;
         func_a_bo <= '0;
         func_b_bo <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (hs) begin
                  state     <= ST_START;
                  func_a_bo <= a_bi;
                  func_b_bo <= b_bi;
               end
            end
            ST_START: state <= ST_WAIT;
            ST_WAIT: begin
               if (push) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   func_ctrl_rfifo u_rfifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push),
      .push_data (push_y),
      .pop       (pop),
      .count     (count),
      .head      (y_bo)
   );

endmodule

// File: tb/tb_func_ctrl.sv
// Directed bench for func_ctrl with a behavioural func core stub
// (fixed latency, optional hang for the watchdog build).
module tb_func_ctrl;
   import func_pkg::*;

`ifdef FUNC_CTRL_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 255;
`endif
   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a_in;
   logic [7:0]  b_in;
   logic        f_start;
   logic [7:0]  f_a;
   logic [7:0]  f_b;
   logic        f_busy;
   logic [24:0] f_y;
   logic        out_valid;
   logic        out_ready;
   logic [24:0] y;
   logic        err;

   int checks = 0;
   int errors = 0;

   func_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .a_bi         (a_in),
      .b_bi         (b_in),
      .func_start_o (f_start),
      .func_a_bo    (f_a),
      .func_b_bo    (f_b),
      .func_busy_i  (f_busy),
      .func_y_bi    (f_y),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .y_bo         (y),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   // core stub: registers start, busy for LAT cycles, then presents y
   logic       hang = 1'b0;
   logic [2:0] lat_cnt;
   logic [7:0] sa;
   logic [7:0] sb;

   function automatic int unsigned isqrt(input int unsigned v);
      int unsigned r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         f_busy  <= 1'b0;
         f_y     <= '0;
         lat_cnt <= '0;
         sa      <= '0;
         sb      <= '0;
      end else if (f_start && !f_busy) begin
         f_busy  <= 1'b1;
         lat_cnt <= 3'(LAT);
         sa      <= f_a;
         sb      <= f_b;
      end else if (f_busy) begin
         if (lat_cnt == 3'd1) begin
            if (!hang) begin
               f_busy <= 1'b0;
               f_y    <= 25'(int'(sa) * int'(sa) * int'(sa) + isqrt(sb));
            end
         end else begin
            lat_cnt <= lat_cnt - 3'd1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // called at a negedge; returns at the negedge after the handshake edge
   task automatic do_op(input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      a_in     = a;
      b_in     = b;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("handshake_timeout", 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      if (!out_valid) chk("out_valid_timeout", 0, 1);
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [24:0] y;
   } vec_t;

   vec_t vecs[8];
   logic [24:0] got[$];
   int   cyc;
   logic hs;
   logic seen;

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{8'd0,   8'd0,   25'd0};
      vecs[1] = '{8'd1,   8'd1,   25'd2};
      vecs[2] = '{8'd2,   8'd2,   25'd9};
      vecs[3] = '{8'd255, 8'd255, 25'd16581390};
      vecs[4] = '{8'd16,  8'd143, 25'd4107};
      vecs[5] = '{8'd43,  8'd11,  25'd79510};
      vecs[6] = '{8'd54,  8'd11,  25'd157467};
      vecs[7] = '{8'd200, 8'd200, 25'd8000014};

      rst       = 1'b1;
      in_valid  = 1'b0;
      a_in      = '0;
      b_in      = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y", y, 0);
      chk("rst_start", f_start, 0);
      chk("rst_func_a", f_a, 0);
      chk("rst_err", err, 0);

      // single op: one-cycle start pulse, held operands
      in_valid = 1'b1;
      a_in     = 8'd2;
      b_in     = 8'd10;
      @(negedge clk);
      chk("start_hi", f_start, 1);
      chk("func_a", f_a, 2);
      chk("func_b", f_b, 10);
      chk("busy_in_ready", in_ready, 0);
      in_valid = 1'b0;
      a_in     = 8'd0;
      b_in     = 8'd0;
      @(negedge clk);
      chk("start_lo", f_start, 0);
      chk("func_a_held", f_a, 2);
      chk("func_b_held", f_b, 10);
      wait_out(cyc);
      chk("single_y", y, 11);
      @(negedge clk);
      chk("single_popped", out_valid, 0);

      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b);
         wait_out(cyc);
         chk($sformatf("vec%0d_y", i), y, vecs[i].y);
         chk($sformatf("vec%0d_lat", i), cyc, 5 + 1);
         @(negedge clk);
         chk($sformatf("vec%0d_pop", i), out_valid, 0);
      end

      // push and pop on the same edge with one entry already queued
      out_ready = 1'b0;
      do_op(8'd3, 8'd0);
      wait_out(cyc);
      chk("pp_first", y, 27);
      do_op(8'd4, 8'd4);
      cyc = 0;
      while (!f_busy && cyc < 50) begin @(negedge clk); cyc++; end
      while (f_busy && cyc < 50) begin @(negedge clk); cyc++; end
      out_ready = 1'b1;
      @(negedge clk);
      chk("pp_y", y, 66);
      chk("pp_valid", out_valid, 1);
      chk("pp_in_ready", in_ready, 1);
      @(negedge clk);
      chk("pp_drained", out_valid, 0);

      // backpressure, in-order drain, operand stability
      out_ready = 1'b0;
      do_op(8'd255, 8'd255);
      do_op(8'd16, 8'd143);
      repeat (12) @(negedge clk);
      in_valid = 1'b1;
      a_in     = 8'd43;
      b_in     = 8'd11;
      repeat (5) @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_head", y, 16581390);
      out_ready = 1'b1;
      got.delete();
      for (int c = 0; c < 60; c++) begin
         hs = in_valid & in_ready;
         if (out_valid) got.push_back(y);
         @(negedge clk);
         if (hs) begin
            in_valid = 1'b0;
            a_in     = 8'd54;
            b_in     = 8'd11;
         end
      end
      chk("bp_count", got.size(), 3);
      if (got.size() == 3) begin
         chk("bp_out0", got[0], 16581390);
         chk("bp_out1", got[1], 4107);
         chk("bp_out2", got[2], 79510);
      end
      chk("stable_a", f_a, 43);
      do_op(8'd54, 8'd11);
      wait_out(cyc);
      chk("stable_next", y, 157467);
      @(negedge clk);

      // reset while waiting on the core
      do_op(8'd100, 8'd100);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_start", f_start, 0);
      chk("mid_rst_a", f_a, 0);
      chk("mid_rst_b", f_b, 0);
      chk("mid_rst_y", y, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_err", err, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1);
      seen = 1'b0;
      repeat (15) begin
         if (out_valid) seen = 1'b1;
         @(negedge clk);
      end
      chk("post_rst_no_result", seen, 0);
      do_op(8'd200, 8'd200);
      wait_out(cyc);
      chk("post_rst_y", y, 8000014);
      @(negedge clk);

`ifdef FUNC_CTRL_TIMEOUT_EN
      hang      = 1'b1;
      out_ready = 1'b0;
      do_op(8'd5, 8'd5);
      wait_out(cyc);
      chk("to_lat", cyc, TO + 1);
      chk("to_sentinel", y, 32'h1FFFFFF);
      chk("to_err", err, 1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("to_popped", out_valid, 0);
      repeat (3) @(negedge clk);
      chk("to_err_sticky", err, 1);
      rst = 1'b1;
      @(negedge clk);
      hang = 1'b0;
      rst  = 1'b0;
      @(negedge clk);
      chk("to_err_clr", err, 0);
`else
      chk("err_tied", err, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
